// File: rtl/debug_frame_sender_if.sv
// Snapshot-read and UART-FIFO signal bundle for debug_frame_sender.
// The sender attaches through the slave modport; its environment uses master.
interface debug_frame_sender_if #(
  parameter int IDX_W = 8
) ();
  logic             start;
  logic [IDX_W-1:0] wordIndex;
  logic [31:0]      wordData;
  logic             fifoFull;
  logic [7:0]       dataToUartOutFifo;
  logic             writeFifoFlag;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output wordData,
    output fifoFull,
    input  wordIndex,
    input  dataToUartOutFifo,
    input  writeFifoFlag,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  wordData,
    input  fifoFull,
    output wordIndex,
    output dataToUartOutFifo,
    output writeFifoFlag,
    output busy,
    output done
  );
endinterface

// File: rtl/debug_frame_sender.sv
// Serialises a frozen debug snapshot as a byte frame into the UART TX FIFO.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module debug_frame_sender #(
  parameter int         WORD_COUNT  = 16,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         IDX_W       = 8
) (
  input logic clock,
  input logic reset,
  debug_frame_sender_if.slave bus
);

  localparam logic [7:0]       COUNT_BYTE = 8'(WORD_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_COUNT - 1);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, HEADER, COUNT, LOAD, BYTE, CSUM, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HEADER, COUNT, LOAD, BYTE, DONE
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       byte_val;
  logic             emit;
`ifdef CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Emitting states hold everything while the FIFO is full.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    byte_val = 8'h00;
    emit     = 1'b0;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = HEADER;
          idx_d   = '0;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HEADER: begin
        emit     = 1'b1;
        byte_val = HEADER_BYTE;
        if (!bus.fifoFull) state_d = COUNT;
      end
      COUNT: begin
        emit     = 1'b1;
        byte_val = COUNT_BYTE;
        if (!bus.fifoFull) begin
          state_d = LOAD;
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ COUNT_BYTE;
`endif
        end
      end
      LOAD: begin
        shift_d = bus.wordData;
        cnt_d   = '0;
        state_d = BYTE;
      end
      BYTE: begin
        emit     = 1'b1;
        byte_val = shift_q[31:24];
        if (!bus.fifoFull) begin
          shift_d = {shift_q[23:0], 8'h00};
          cnt_d   = cnt_q + 2'd1;
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[31:24];
`endif
          if (cnt_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
`ifdef CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
`endif
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
`ifdef CHECKSUM_EN
      CSUM: begin
        emit     = 1'b1;
        byte_val = csum_q;
        if (!bus.fifoFull) state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wordIndex         = idx_q;
  assign bus.dataToUartOutFifo = byte_val;
  assign bus.writeFifoFlag     = emit & ~bus.fifoFull;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == DONE);

endmodule

// File: tb/tb_debug_frame_sender.sv
// Directed bench for debug_frame_sender: two-word and one-word frames,
// FIFO back-pressure, ignored restarts and mid-frame reset.
module tb_debug_frame_sender;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_frame_sender_if #(.IDX_W(8)) ifc2 ();
  debug_frame_sender_if #(.IDX_W(8)) ifc1 ();

  debug_frame_sender #(.WORD_COUNT(2)) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (ifc2.slave)
  );

  debug_frame_sender #(.WORD_COUNT(1)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (ifc1.slave)
  );

  assign ifc2.wordData = (ifc2.wordIndex == 8'd0) ? 32'h11223344
                                                  : 32'hAABBCCDD;
  assign ifc1.wordData = 32'hFFFFFFFF;

  int total = 0;
  int bad   = 0;
  int gcyc  = 0;
  int t0    = 0;
  int done2_n, done1_n, done2_at, done1_at;
  logic [7:0] q2[$];
  logic [7:0] q1[$];
  logic [7:0] exp2[$];
  logic [7:0] exp1[$];
  int done2_exp, done1_exp;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(negedge clk) begin
    if (ifc2.writeFifoFlag) q2.push_back(ifc2.dataToUartOutFifo);
    if (ifc1.writeFifoFlag) q1.push_back(ifc1.dataToUartOutFifo);
    if (ifc2.done) begin done2_n++; done2_at = gcyc - t0 + 1; end
    if (ifc1.done) begin done1_n++; done1_at = gcyc - t0 + 1; end
    if (ifc2.fifoFull) chk("no_wr_when_full2", ifc2.writeFifoFlag, 1'b0);
    if (ifc1.fifoFull) chk("no_wr_when_full1", ifc1.writeFifoFlag, 1'b0);
  end

  task automatic check_frame(input string tag,
                             input logic [7:0] got[$],
                             input logic [7:0] exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk({tag, "_byte"}, got[i], exp[i]);
  endtask

  // Leaves the bench 1 time unit after edge 0, i.e. inside cycle 1.
  task automatic start2();
    @(posedge clk); #1;
    q2.delete(); done2_n = 0; done2_at = 0;
    ifc2.start = 1'b1;
    @(posedge clk); #1;
    ifc2.start = 1'b0;
    t0 = gcyc;
  endtask

  task automatic start1();
    @(posedge clk); #1;
    q1.delete(); done1_n = 0; done1_at = 0;
    ifc1.start = 1'b1;
    @(posedge clk); #1;
    ifc1.start = 1'b0;
    t0 = gcyc;
  endtask

  task automatic wait_done2(input int bound);
    int k = 0;
    while (done2_n == 0 && k < bound) begin @(posedge clk); k++; end
    chk("done2_seen", (done2_n > 0), 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    ifc2.start = 1'b0; ifc2.fifoFull = 1'b0;
    ifc1.start = 1'b0; ifc1.fifoFull = 1'b0;
    done2_n = 0; done1_n = 0; done2_at = 0; done1_at = 0;
`ifdef CHECKSUM_EN
    exp2 = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    exp1 = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    done2_exp = 14; done1_exp = 15;
`else
    exp2 = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp1 = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    done2_exp = 13; done1_exp = 13;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_idx", ifc2.wordIndex, 8'd0);
    chk("rst_data", ifc2.dataToUartOutFifo, 8'h00);
    chk("rst_wr", ifc2.writeFifoFlag, 1'b0);
    chk("rst_busy", ifc2.busy, 1'b0);
    chk("rst_done", ifc2.done, 1'b0);
    chk("rst_busy1", ifc1.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // plain two-word frame
    start2();
    @(negedge clk);
    chk("t1_busy_c1", ifc2.busy, 1'b1);
    chk("t1_hdr_c1", ifc2.dataToUartOutFifo, 8'hA5);
    chk("t1_wr_c1", ifc2.writeFifoFlag, 1'b1);
    wait_done2(60);
    chk("t1_done_cyc", done2_at, done2_exp);
    @(negedge clk);
    chk("t1_busy_after", ifc2.busy, 1'b0);
    chk("t1_idx_max", ifc2.wordIndex, 8'd1);
    check_frame("t1", q2, exp2);

    // back-pressure during byte 0x33
    start2();
    repeat (5) @(posedge clk);
    #1 ifc2.fifoFull = 1'b1;
    @(negedge clk);
    chk("t2_held_data", ifc2.dataToUartOutFifo, 8'h33);
    chk("t2_held_wr", ifc2.writeFifoFlag, 1'b0);
    repeat (3) @(posedge clk);
    #1 ifc2.fifoFull = 1'b0;
    wait_done2(60);
    chk("t2_done_cyc", done2_at, done2_exp + 3);
    check_frame("t2", q2, exp2);

    // restart request mid-frame is ignored
    start2();
    repeat (4) @(posedge clk);
    #1 ifc2.start = 1'b1;
    @(posedge clk);
    #1 ifc2.start = 1'b0;
    wait_done2(60);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_one_done", done2_n, 1);
    chk("t4_busy_after", ifc2.busy, 1'b0);
    check_frame("t4", q2, exp2);

    // reset in cycle 6, then a fresh frame
    start2();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_idx", ifc2.wordIndex, 8'd0);
    chk("t5_data", ifc2.dataToUartOutFifo, 8'h00);
    chk("t5_wr", ifc2.writeFifoFlag, 1'b0);
    chk("t5_busy", ifc2.busy, 1'b0);
    chk("t5_done", ifc2.done, 1'b0);
    start2();
    wait_done2(60);
    chk("t5_done_cyc", done2_at, done2_exp);
    check_frame("t5", q2, exp2);

    // one all-ones word with fifoFull toggling each cycle
    start1();
    ifc1.fifoFull = 1'b1;
    for (int k = 0; k < 60 && done1_n == 0; k++) begin
      @(posedge clk);
      #1 ifc1.fifoFull = ~ifc1.fifoFull;
    end
    ifc1.fifoFull = 1'b0;
    chk("t6_done_seen", (done1_n > 0), 1'b1);
    chk("t6_done_cyc", done1_at, done1_exp);
    check_frame("t6", q1, exp1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
